// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Define CPU_HALT_EN to build opcode 7 as HALT with a sticky halted flag; otherwise opcode 7 is a NOP.
module cpu_control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] mem_data_out,
    output logic [3:0] mem_address,
    output logic [1:0] mem_ctrl,
    output logic [7:0] mem_data_in,
    output logic [7:0] ac,
    output logic [3:0] pc,
    output logic [7:0] ir,
    output logic       instr_done,
    output logic       halted
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
`ifdef CPU_HALT_EN
    localparam logic [2:0] S_HALT   = 3'd6;
`endif

    localparam logic [1:0] CTRL_NONE  = 2'b00;
    localparam logic [1:0] CTRL_READ  = 2'b01;
    localparam logic [1:0] CTRL_WRITE = 2'b10;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        opcode;

    assign opcode      = ir[7:4];
    assign mem_data_in = ac;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and combinational memory/handshake outputs
    always_comb begin
        state_d     = state_q;
        mem_address = ar;
        mem_ctrl    = CTRL_NONE;
        instr_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run && !halted) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_address = pc;
                mem_ctrl    = CTRL_READ;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    4'd5: state_d = S_WRITE;
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6: state_d = S_READ;
`ifdef CPU_HALT_EN
                    4'd7: begin
                        instr_done = 1'b1;
                        state_d    = S_HALT;
                    end
`endif
                    default: begin
                        instr_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                endcase
            end
            S_READ: begin
                mem_ctrl = CTRL_READ;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                instr_done = 1'b1;
                state_d    = S_IDLE;
            end
            S_WRITE: begin
                mem_ctrl   = CTRL_WRITE;
                instr_done = 1'b1;
                state_d    = S_IDLE;
            end
`ifdef CPU_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulator update for the operand instructions; carry of ADD is dropped
    always_comb begin
        alu_res = ac;
        case (opcode)
            4'd0:    alu_res = DATA_W'(ac + dr);
            4'd1:    alu_res = {dr[6:0], 1'b0};
            4'd2:    alu_res = ~(ac ^ dr);
            4'd3:    alu_res = {dr[7], dr[7:1]};
            4'd4:    alu_res = dr;
            4'd6:    alu_res = DATA_W'(~dr + DATA_W'(1));
            default: alu_res = ac;
        endcase
    end

    // Architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            ir <= '0;
            ar <= '0;
            dr <= '0;
            ac <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir <= mem_data_out;
                    pc <= ADDR_W'(pc + ADDR_W'(1));
                end
                S_DECODE: ar <= ir[3:0];
                S_READ:   dr <= mem_data_out;
                S_EXEC:   ac <= alu_res;
                default: ;
            endcase
        end
    end

`ifdef CPU_HALT_EN
    // Sticky until reset; set on the edge that enters HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (state_d == S_HALT) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit with a 16x8 memory model attached.
module tb_cpu_control_unit;

    typedef struct {
        logic [7:0] ac;
        logic [3:0] pc;
        int         spacing;
        logic [7:0] m15;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] mem_data_out;
    logic [3:0] mem_address;
    logic [1:0] mem_ctrl;
    logic [7:0] mem_data_in;
    logic [7:0] ac;
    logic [3:0] pc;
    logic [7:0] ir;
    logic       instr_done;
    logic       halted;

    logic [7:0] mem [16];
    logic [7:0] init_img [16];
    exp_t       sb [$];
    bit         pend = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;

    cpu_control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .mem_data_out (mem_data_out),
        .mem_address  (mem_address),
        .mem_ctrl     (mem_ctrl),
        .mem_data_in  (mem_data_in),
        .ac           (ac),
        .pc           (pc),
        .ir           (ir),
        .instr_done   (instr_done),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge, image reloaded while in reset
    assign mem_data_out = mem[mem_address];
    always @(posedge clk) begin
        if (!rst_n) mem <= init_img;
        else if (mem_ctrl[1]) mem[mem_address] <= mem_data_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [7:0] a, input logic [3:0] p, input int sp, input logic [7:0] m);
        exp_t e;
        e.ac = a; e.pc = p; e.spacing = sp; e.m15 = m;
        sb.push_back(e);
    endtask

    // Monitor: pops one entry per instr_done pulse, checks AC/PC/M[15] on the following cycle
    initial begin : monitor
        int   cyc = 0;
        int   last = 0;
        exp_t cur;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                check("ac_after_instr", 32'(ac), 32'(cur.ac));
                check("pc_after_instr", 32'(pc), 32'(cur.pc));
                check("mem15_after_instr", 32'(mem[15]), 32'(cur.m15));
                pend = 1'b0;
            end
            if (instr_done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_instr_done", 32'(1), 32'(0));
                end else begin
                    cur = sb.pop_front();
                    if (cur.spacing != 0) check("done_spacing", 32'(cyc - last), 32'(cur.spacing));
                    pend = 1'b1;
                end
                last = cyc;
            end
        end
    end

    task automatic reset_with(input logic [7:0] fill);
        run   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) init_img[i] = fill;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int n);
        int cnt = 0;
        int k = 0;
        while (cnt < n && k < 500) begin
            @(negedge clk);
            k++;
            if (instr_done === 1'b1) cnt++;
        end
        run = 1'b0;
        check("wait_done_timeout", 32'(cnt), 32'(n));
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || pend) && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
    endtask

    task automatic idle_hold(input string name, input logic [3:0] exp_pc, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({name, "_ctrl"}, 32'(mem_ctrl), 32'(0));
            check({name, "_pc"}, 32'(pc), 32'(exp_pc));
        end
    endtask

    task automatic load_program();
        reset_with(8'h00);
        init_img[0]  = 8'h48;
        init_img[1]  = 8'h09;
        init_img[2]  = 8'h5F;
        init_img[3]  = 8'h1F;
        init_img[4]  = 8'h29;
        init_img[5]  = 8'h5F;
        init_img[6]  = 8'h3F;
        init_img[7]  = 8'h6B;
        init_img[8]  = 8'h04;
        init_img[9]  = 8'h06;
        init_img[11] = 8'h04;
    endtask

    initial begin : stim
        int k;
        // Reset state
        load_program();
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'(0));
        check("rst_ac", 32'(ac), 32'(0));
        check("rst_ir", 32'(ir), 32'(0));
        check("rst_ctrl", 32'(mem_ctrl), 32'(0));
        check("rst_done", 32'(instr_done), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        release_reset();

        // Eight-instruction program
        push(8'h04, 4'd1, 0, 8'h00);
        push(8'h0A, 4'd2, 5, 8'h00);
        push(8'h0A, 4'd3, 4, 8'h0A);
        push(8'h14, 4'd4, 5, 8'h0A);
        push(8'hED, 4'd5, 5, 8'h0A);
        push(8'hED, 4'd6, 4, 8'hED);
        push(8'hF6, 4'd7, 5, 8'hED);
        push(8'hFC, 4'd8, 5, 8'hED);
        run = 1'b1;
        wait_done(8);
        drain();
        idle_hold("prog_idle", 4'd8, 3);

        // run dropped during FETCH: LOAD still completes, then IDLE holds
        load_program();
        release_reset();
        push(8'h04, 4'd1, 0, 8'h00);
        run = 1'b1;
        k = 0;
        while (mem_ctrl !== 2'b01 && k < 20) begin @(negedge clk); k++; end
        run = 1'b0;
        check("runlow_saw_fetch", 32'(mem_ctrl), 32'(1));
        drain();
        idle_hold("runlow_idle", 4'd1, 5);

        // PC wrap over 16 NOPs
        reset_with(8'hF0);
        release_reset();
        for (int i = 0; i < 16; i++) push(8'h00, 4'((i + 1) % 16), (i == 0) ? 0 : 3, 8'hF0);
        run = 1'b1;
        wait_done(16);
        drain();
        idle_hold("wrap_idle", 4'd0, 2);

        // Reset during WRITE of STORE to M[15] with AC=0x55
        reset_with(8'h00);
        init_img[0]  = 8'h48;
        init_img[1]  = 8'h5F;
        init_img[8]  = 8'h55;
        init_img[15] = 8'h33;
        release_reset();
        push(8'h55, 4'd1, 0, 8'h33);
        push(8'h00, 4'd0, 4, 8'h33);
        run = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (mem_ctrl !== 2'b10 && k < 30);
        check("rstw_saw_write", 32'(mem_ctrl), 32'(2));
        #1 rst_n = 1'b0;
        run = 1'b0;
        #2 rst_n = 1'b1;
        drain();
        idle_hold("rstw_idle", 4'd0, 3);
        check("rstw_ac", 32'(ac), 32'(0));
        check("rstw_mem15", 32'(mem[15]), 32'(8'h33));

        // Opcode 7
        reset_with(8'hF0);
        init_img[0] = 8'h70;
        release_reset();
`ifdef CPU_HALT_EN
        push(8'h00, 4'd1, 0, 8'hF0);
        run = 1'b1;
        repeat (2) @(negedge clk);
        check("halt_not_yet", 32'(halted), 32'(0));
        run = 1'b0;
        @(negedge clk);
        check("halt_set", 32'(halted), 32'(1));
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_sticky", 32'(halted), 32'(1));
            check("halt_pc", 32'(pc), 32'(1));
            check("halt_ctrl", 32'(mem_ctrl), 32'(0));
        end
        run = 1'b0;
        drain();
`else
        push(8'h00, 4'd1, 0, 8'hF0);
        push(8'h00, 4'd2, 3, 8'hF0);
        run = 1'b1;
        wait_done(2);
        drain();
        check("nohalt_flag", 32'(halted), 32'(0));
        idle_hold("nohalt_idle", 4'd2, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
